// File: rtl/perf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : perf_pkg
//  Purpose  : Shared sizes, counter index map and read-FSM state type for the
//             performance event counter block.
//  Revision : 1.0 - initial release
// ============================================================================
package perf_pkg;

  localparam int NUM_CNT    = 8;
  localparam int NUM_HW_CNT = 7;
  localparam int CNT_W      = 64;
  localparam int HALF_W     = 32;
  localparam int IDX_W      = 3;

  localparam logic [IDX_W-1:0] IDX_CYCLES    = 3'd0;
  localparam logic [IDX_W-1:0] IDX_IFU_FETCH = 3'd1;
  localparam logic [IDX_W-1:0] IDX_IC_ACCESS = 3'd2;
  localparam logic [IDX_W-1:0] IDX_IC_HIT    = 3'd3;
  localparam logic [IDX_W-1:0] IDX_LSU_LOAD  = 3'd4;
  localparam logic [IDX_W-1:0] IDX_LSU_STORE = 3'd5;
  localparam logic [IDX_W-1:0] IDX_LSU_WAIT  = 3'd6;
  localparam logic [IDX_W-1:0] IDX_NONE      = 3'd7;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/perf_cnt64.sv
`default_nettype none
// ============================================================================
//  Module   : perf_cnt64
//  Purpose  : 64-bit wrapping event counter with clear and count enable.
//  Revision : 1.0 - initial release
// ============================================================================
module perf_cnt64
  import perf_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // Clear has priority over increment; overflow wraps to zero naturally.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && i_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/perf_event_counters.sv
`default_nettype none
// ============================================================================
//  Module   : perf_event_counters
//  Purpose  : Seven 64-bit performance counters with a tear-free 32-bit
//             read port (low word latches the high word into a shadow).
//  Revision : 1.0 - initial release
// ============================================================================
module perf_event_counters
  import perf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ifu_valid,
  input  logic              i_icache_start,
  input  logic              i_icache_valid,
  input  logic              i_icache_isHit,
  input  logic              i_lsu_ren,
  input  logic              i_lsu_wen,
  input  logic              i_lsu_isWaiting,
  input  logic              i_cnt_en,
  input  logic              i_cnt_clr,
  input  logic              i_rd_req_valid,
  output logic              o_rd_req_ready,
  input  logic [IDX_W-1:0]  i_rd_req_idx,
  input  logic              i_rd_req_hi,
  output logic              o_rd_resp_valid,
  input  logic              i_rd_resp_ready,
  output logic [HALF_W-1:0] o_rd_resp_data
);

  logic [4:0]            w_lvl;
  logic [4:0]            r_prev;
  logic [4:0]            w_edge;
  logic [NUM_HW_CNT-1:0] w_inc;
  logic [CNT_W-1:0]      w_cnt [NUM_CNT];
  logic [CNT_W-1:0]      w_sel;
  logic [HALF_W-1:0]     w_rd_word;
  logic                  w_accept;
  rd_state_e             r_state;
  logic [HALF_W-1:0]     r_data;
  logic [HALF_W-1:0]     r_shadow;

  assign w_lvl = {i_lsu_isWaiting & i_lsu_wen,
                  i_lsu_isWaiting & i_lsu_ren,
                  i_icache_valid  & i_icache_isHit,
                  i_icache_start,
                  i_ifu_valid};

  // History tracks levels even while counting is frozen, so re-enable never
  // sees a stale rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= '0;
    end else begin
      r_prev <= w_lvl;
    end
  end

  assign w_edge = w_lvl & ~r_prev;

  assign w_inc[IDX_CYCLES]    = 1'b1;
  assign w_inc[IDX_IFU_FETCH] = w_edge[0];
  assign w_inc[IDX_IC_ACCESS] = w_edge[1];
  assign w_inc[IDX_IC_HIT]    = w_edge[2];
  assign w_inc[IDX_LSU_LOAD]  = w_edge[3];
  assign w_inc[IDX_LSU_STORE] = w_edge[4];
  assign w_inc[IDX_LSU_WAIT]  = i_lsu_isWaiting;

  for (genvar gi = 0; gi < NUM_HW_CNT; gi++) begin : g_cnt
    perf_cnt64 u_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_en  (i_cnt_en),
      .i_inc (w_inc[gi]),
      .i_clr (i_cnt_clr),
      .o_cnt (w_cnt[gi])
    );
  end

  assign w_cnt[IDX_NONE] = '0;

  assign w_sel     = w_cnt[i_rd_req_idx];
  assign w_rd_word = i_rd_req_hi ? r_shadow : w_sel[HALF_W-1:0];
  assign w_accept  = i_rd_req_valid && (r_state == RD_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= RD_IDLE;
      r_data   <= '0;
      r_shadow <= '0;
    end else if (r_state == RD_IDLE) begin
      if (w_accept) begin
        r_state <= RD_RESP;
        r_data  <= w_rd_word;
        if (!i_rd_req_hi) begin
          r_shadow <= w_sel[CNT_W-1:HALF_W];
        end
      end
    end else if (i_rd_resp_ready) begin
      r_state <= RD_IDLE;
    end
  end

  assign o_rd_req_ready  = (r_state == RD_IDLE);
  assign o_rd_resp_valid = (r_state == RD_RESP);
  assign o_rd_resp_data  = r_data;

endmodule
`default_nettype wire

// File: doc/perf_event_counters.md
PERF_EVENT_COUNTERS -- requirements
Module: perf_event_counters

Interface
REQ-001 SHALL have clock  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have ifu_valid  input  1  fetch-valid level from IFU.
REQ-004 SHALL have icache_start  input  1  I-cache access-start level.
REQ-005 SHALL have icache_valid  input  1  I-cache result-valid level.
REQ-006 SHALL have icache_isHit  input  1  hit flag, qualified by icache_valid.
REQ-007 SHALL have lsu_ren, lsu_wen  input  1 each  LSU access type, qualified by lsu_isWaiting.
REQ-008 SHALL have lsu_isWaiting  input  1  LSU waiting on memory.
REQ-009 SHALL have cnt_en  input  1  count enable; 0 freezes all counters.
REQ-010 SHALL have cnt_clr  input  1  clear-all pulse.
REQ-011 SHALL have rd_req_valid / rd_req_ready  input / output  1  read-request handshake.
REQ-012 SHALL have rd_req_idx  input  3  counter index; rd_req_hi  input  1  0 = low word, 1 = high word.
REQ-013 SHALL have rd_resp_valid / rd_resp_ready  output / input  1  read-response handshake.
REQ-014 SHALL have rd_resp_data  output  32  read data.

Function
REQ-015 SHALL hold seven 64-bit counters: 0 cycles, 1 ifu_fetch, 2 icache_access, 3 icache_hit, 4 lsu_load, 5 lsu_store, 6 lsu_wait_cycles; index 7 SHALL read 0.
REQ-016 Event counters 1-5 SHALL count 0->1 edges: ifu_valid; icache_start; icache_valid with icache_isHit=1; lsu_isWaiting with lsu_ren=1; lsu_isWaiting with lsu_wen=1.
REQ-017 Edge detection SHALL use registered previous values, reset to 0; a level already high on the first cycle after reset counts as one edge.
REQ-018 Counter 0 SHALL increment every cycle and counter 6 every cycle lsu_isWaiting=1, both only while cnt_en=1.
REQ-019 With cnt_en=0, edge-history registers SHALL still update so no spurious edge follows re-enable.
REQ-020 Counters SHALL wrap 0xFFFF_FFFF_FFFF_FFFF -> 0 silently.
REQ-021 cnt_clr=1 SHALL zero all counters next cycle; clear wins over a simultaneous increment.
REQ-022 Read FSM SHALL have states IDLE and RESP; rd_req_ready=1 only in IDLE.
REQ-023 Request accepted (valid and ready in IDLE) SHALL go to RESP; rd_resp_valid=1 the next cycle with data registered, latency exactly 1.
REQ-024 In RESP, rd_resp_data and rd_resp_valid SHALL hold stable until rd_resp_ready=1, then return to IDLE; no back-to-back acceptance in the same cycle.
REQ-025 A low-word read SHALL latch the same-cycle high word of that counter into a 32-bit shadow; high-word reads SHALL return the shadow, giving tear-free 64-bit reads (low then high).
REQ-026 High-word read without a prior low read SHALL return the shadow's current value (0 after reset).
REQ-027 Read data SHALL reflect counter values in the accept cycle, before that cycle's increment.
REQ-028 cnt_clr SHALL NOT affect the read FSM, pending response, or shadow.

Reset
REQ-029 reset SHALL zero all counters, edge history, and the shadow; FSM -> IDLE; rd_resp_valid=0; rd_resp_data=0; rd_req_ready=1 the first cycle after release.
REQ-030 Reset during RESP SHALL drop the pending response without completing it.
REQ-031 All events SHALL be ignored while reset=1.

Structure
REQ-032 Package perf_pkg SHALL define NUM_CNT=8, CNT_W=64, the counter index constants, and the FSM state enum.
REQ-033 A sub-module perf_cnt64 (64-bit counter with inc, clr, en) SHALL be instantiated once per counter.

Verification
REQ-034 Reset, then 10 cycles of cnt_en=1 with no events -> read idx0 lo returns 10 (plus response latency per REQ-027); idx1-6 return 0.
REQ-035 Pulse ifu_valid high for 3 cycles three separate times -> idx1 lo = 3; hold lsu_isWaiting 5 cycles with lsu_ren=1 -> idx4 = 1, idx6 = 5.
REQ-036 Preload idx0 to 0x0000_0000_FFFF_FFFF; read lo; run 2 cycles; read hi -> hi returns 0 (shadow), not 1.
REQ-037 Assert cnt_clr in the same cycle as an icache_valid edge with isHit=1 -> idx3 = 0.
REQ-038 Accept a request, hold rd_resp_ready=0 for 4 cycles -> data stable, rd_req_ready=0 throughout; assert reset in cycle 3 -> rd_resp_valid=0 next cycle.
REQ-039 Read idx7 hi and lo -> 0; preload a counter to all-ones, one increment -> reads 0.
